// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IC refill, DM access) to one-slave memory arbiter.
// Shares one req/ack memory port and returns a one-cycle ready pulse with
// registered read data to the master that was served.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_ic_req/i_ic_addr      IC fetch request (held until o_ic_ready)
//   o_ic_ready/o_ic_rdata   IC response pulse and fetched word
//   i_dm_rd/i_dm_wr         DM read/write request (held until o_dm_ready)
//   i_dm_addr/wd/f3         DM address, write data, access size/sign
//   o_dm_ready/o_dm_rdata   DM response pulse and read data (0 on writes)
//   o_mem_req/we/addr/wd/f3 shared memory request, held until i_mem_ack
//   i_mem_ack/i_mem_rdata   memory completion and read data
//
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on a tie;
// without it the DM master always wins over IC.

module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ic_req,
    input  logic [XLEN-1:0] i_ic_addr,
    output logic            o_ic_ready,
    output logic [XLEN-1:0] o_ic_rdata,
    input  logic            i_dm_rd,
    input  logic            i_dm_wr,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wd,
    input  logic [2:0]      i_dm_f3,
    output logic            o_dm_ready,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wd,
    output logic [2:0]      o_mem_f3,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IC,
        BUSY_DM,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wd_q, mem_wd_d;
    logic [2:0]        mem_f3_q, mem_f3_d;
    logic              ic_ready_q, ic_ready_d;
    logic [XLEN-1:0]   ic_rdata_q, ic_rdata_d;
    logic              dm_ready_q, dm_ready_d;
    logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;

    logic              dm_pend;
    logic              ic_pend;
    logic              grant_dm;
    logic              grant_ic;

    assign dm_pend = i_dm_rd | i_dm_wr;
    assign ic_pend = i_ic_req;

`ifdef MEM_ARB_RR_EN
    // Remembers whether DM took the previous grant; a tie goes to the
    // other master.
    logic              last_dm_q, last_dm_d;

    assign grant_dm = dm_pend & (~ic_pend | ~last_dm_q);
`else
    assign grant_dm = dm_pend;
`endif
    assign grant_ic = ic_pend & ~grant_dm;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        mem_f3_d   = mem_f3_q;
        ic_ready_d = 1'b0;
        ic_rdata_d = ic_rdata_q;
        dm_ready_d = 1'b0;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_dm_d  = last_dm_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d    = BUSY_DM;
                    mem_req_d  = 1'b1;
                    // rd and wr together resolve to a write
                    mem_we_d   = i_dm_wr;
                    mem_addr_d = i_dm_addr;
                    mem_wd_d   = i_dm_wd;
                    mem_f3_d   = i_dm_f3;
                end else if (grant_ic) begin
                    state_d    = BUSY_IC;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_ic_addr;
                    mem_wd_d   = '0;
                    mem_f3_d   = F3_WORD;
                end
`ifdef MEM_ARB_RR_EN
                if (grant_dm | grant_ic) begin
                    last_dm_d = grant_dm;
                end
`endif
            end
            BUSY_IC: begin
                if (i_mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    ic_ready_d = 1'b1;
                    ic_rdata_d = i_mem_rdata;
                end
            end
            BUSY_DM: begin
                if (i_mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    dm_ready_d = 1'b1;
                    dm_rdata_d = mem_we_q ? '0 : i_mem_rdata;
                end
            end
            RESP: begin
                // ready pulse is on the outputs this cycle
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            mem_f3_q   <= '0;
            ic_ready_q <= 1'b0;
            ic_rdata_q <= '0;
            dm_ready_q <= 1'b0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            mem_f3_q   <= mem_f3_d;
            ic_ready_q <= ic_ready_d;
            ic_rdata_q <= ic_rdata_d;
            dm_ready_q <= dm_ready_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Resets to "IC granted last" so DM wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`endif

    assign o_mem_req  = mem_req_q;
    assign o_mem_we   = mem_we_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_wd   = mem_wd_q;
    assign o_mem_f3   = mem_f3_q;
    assign o_ic_ready = ic_ready_q;
    assign o_ic_rdata = ic_rdata_q;
    assign o_dm_ready = dm_ready_q;
    assign o_dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Directed table, corner sequences, and random traffic vs a reference model.

module tb_mem_arbiter;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dm_rd, dm_wr;
    logic [31:0] dm_addr, dm_wd;
    logic [2:0]  dm_f3;
    logic        ack_drv;
    logic [31:0] rdata_drv;
    bit          zw_mode = 1'b0;

    logic        o_ic_ready, o_dm_ready;
    logic [31:0] o_ic_rdata, o_dm_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wd;
    logic [2:0]  o_mem_f3;
    logic        mem_ack;

    // zero-wait memory acknowledges whatever it is asked
    assign mem_ack = zw_mode ? o_mem_req : ack_drv;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ic_req(ic_req), .i_ic_addr(ic_addr),
        .o_ic_ready(o_ic_ready), .o_ic_rdata(o_ic_rdata),
        .i_dm_rd(dm_rd), .i_dm_wr(dm_wr),
        .i_dm_addr(dm_addr), .i_dm_wd(dm_wd), .i_dm_f3(dm_f3),
        .o_dm_ready(o_dm_ready), .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wd(o_mem_wd), .o_mem_f3(o_mem_f3),
        .i_mem_ack(mem_ack), .i_mem_rdata(rdata_drv)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        icq;
        logic [31:0] ica;
        logic        rd, wr;
        logic [31:0] da, wd;
        logic [2:0]  f3;
        logic        ack;
        logic [31:0] rdat;
        logic [134:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [134:0] outs();
        return {o_mem_req, o_mem_we, o_mem_addr, o_mem_wd, o_mem_f3,
                o_ic_ready, o_ic_rdata, o_dm_ready, o_dm_rdata};
    endfunction

    function automatic logic [134:0] pk(
        logic req, logic we, logic [31:0] addr, logic [31:0] wd,
        logic [2:0] f3, logic icr, logic [31:0] icd,
        logic dmr, logic [31:0] dmd);
        return {req, we, addr, wd, f3, icr, icd, dmr, dmd};
    endfunction

    function automatic vec_t mk(
        logic icq, logic [31:0] ica, logic rd, logic wr,
        logic [31:0] da, logic [31:0] wd, logic [2:0] f3,
        logic ack, logic [31:0] rdat, logic [134:0] e);
        vec_t v;
        v.icq = icq; v.ica = ica; v.rd = rd; v.wr = wr;
        v.da = da; v.wd = wd; v.f3 = f3;
        v.ack = ack; v.rdat = rdat; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [134:0] act,
                       input logic [134:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        ic_req = 1'b0; ic_addr = '0;
        dm_rd = 1'b0; dm_wr = 1'b0;
        dm_addr = '0; dm_wd = '0; dm_f3 = '0;
        ack_drv = 1'b0; rdata_drv = '0;
    endtask

    task automatic rand_in();
        ic_req = 1'($urandom); ic_addr = $urandom;
        dm_rd = 1'($urandom); dm_wr = 1'($urandom);
        dm_addr = $urandom; dm_wd = $urandom; dm_f3 = 3'($urandom);
        ack_drv = 1'b1; rdata_drv = $urandom;
    endtask

    task automatic do_reset();
        zw_mode = 1'b0;
        idle_in();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // reference model state (transaction view)
    int          m_owner;
    bit          m_resp;
    bit          m_last_dm;
    logic        e_req, e_we, e_icr, e_dmr;
    logic [31:0] e_addr, e_wd, e_icd, e_dmd;
    logic [2:0]  e_f3;

    task automatic model_step();
        bit take_dm;
        if (!rst) begin
            e_req = 0; e_we = 0; e_icr = 0; e_dmr = 0;
            e_addr = 0; e_wd = 0; e_f3 = 0; e_icd = 0; e_dmd = 0;
            m_owner = 0; m_resp = 0; m_last_dm = 0;
            return;
        end
        e_icr = 0;
        e_dmr = 0;
        if (m_resp) begin
            m_resp = 0;
            m_owner = 0;
        end else if (m_owner != 0) begin
            if (ack_drv) begin
                e_req = 0;
                m_resp = 1;
                if (m_owner == 1) begin
                    e_icr = 1; e_icd = rdata_drv;
                end else begin
                    e_dmr = 1; e_dmd = e_we ? 32'h0 : rdata_drv;
                end
            end
        end else begin
            take_dm = (dm_rd | dm_wr) && !(ic_req && RR && m_last_dm);
            if (take_dm) begin
                e_req = 1; e_we = dm_wr; e_addr = dm_addr;
                e_wd = dm_wd; e_f3 = dm_f3;
                m_owner = 2; m_last_dm = 1;
            end else if (ic_req) begin
                e_req = 1; e_we = 0; e_addr = ic_addr;
                e_wd = 0; e_f3 = 3'b010;
                m_owner = 1; m_last_dm = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] ea;
        logic [31:0] ed;
        int g;

        // reset with random inputs and ack
        rst = 1'b0;
        rand_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset%0d", i), outs(), '0);
            rand_in();
        end

        // directed table: IC fetch with waits, then IC/DM tie
        tbl[0]  = mk(Y, 32'h100, N, N, 0, 0, 3'd0, N, 0,
                     pk(N, N, 0, 0, 3'd0, N, 0, N, 0));
        tbl[1]  = mk(Y, 32'h100, N, N, 0, 0, 3'd0, N, 0,
                     pk(Y, N, 32'h100, 0, 3'd2, N, 0, N, 0));
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(Y, 32'h100, N, N, 0, 0, 3'd0, Y, 32'h13,
                     pk(Y, N, 32'h100, 0, 3'd2, N, 0, N, 0));
        tbl[5]  = mk(Y, 32'h100, N, N, 0, 0, 3'd0, N, 0,
                     pk(N, N, 32'h100, 0, 3'd2, Y, 32'h13, N, 0));
        tbl[6]  = mk(N, 0, N, N, 0, 0, 3'd0, N, 0,
                     pk(N, N, 32'h100, 0, 3'd2, N, 32'h13, N, 0));
        tbl[7]  = mk(Y, 32'h200, N, Y, 32'h2000, 32'hDEADBEEF, 3'd2, N, 0,
                     pk(N, N, 32'h100, 0, 3'd2, N, 32'h13, N, 0));
        tbl[8]  = mk(Y, 32'h200, N, Y, 32'h2000, 32'hDEADBEEF, 3'd2, N, 0,
                     pk(Y, Y, 32'h2000, 32'hDEADBEEF, 3'd2,
                        N, 32'h13, N, 0));
        tbl[9]  = mk(Y, 32'h200, N, Y, 32'h2000, 32'hDEADBEEF, 3'd2,
                     Y, 32'h55555555,
                     pk(Y, Y, 32'h2000, 32'hDEADBEEF, 3'd2,
                        N, 32'h13, N, 0));
        tbl[10] = mk(Y, 32'h200, N, Y, 32'h2000, 32'hDEADBEEF, 3'd2, N, 0,
                     pk(N, Y, 32'h2000, 32'hDEADBEEF, 3'd2,
                        N, 32'h13, Y, 0));
        tbl[11] = mk(Y, 32'h200, N, N, 0, 0, 3'd0, N, 0,
                     pk(N, Y, 32'h2000, 32'hDEADBEEF, 3'd2,
                        N, 32'h13, N, 0));
        tbl[12] = mk(Y, 32'h200, N, N, 0, 0, 3'd0, Y, 32'hAAAA0001,
                     pk(Y, N, 32'h200, 0, 3'd2, N, 32'h13, N, 0));
        tbl[13] = mk(Y, 32'h200, N, N, 0, 0, 3'd0, N, 0,
                     pk(N, N, 32'h200, 0, 3'd2, Y, 32'hAAAA0001, N, 0));
        tbl[14] = mk(N, 0, N, N, 0, 0, 3'd0, Y, 32'h77,
                     pk(N, N, 32'h200, 0, 3'd2, N, 32'hAAAA0001, N, 0));
        tbl[15] = mk(N, 0, N, N, 0, 0, 3'd0, N, 0,
                     pk(N, N, 32'h200, 0, 3'd2, N, 32'hAAAA0001, N, 0));

        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d", i), outs(), tbl[i].exp);
            ic_req = tbl[i].icq; ic_addr = tbl[i].ica;
            dm_rd = tbl[i].rd; dm_wr = tbl[i].wr;
            dm_addr = tbl[i].da; dm_wd = tbl[i].wd; dm_f3 = tbl[i].f3;
            ack_drv = tbl[i].ack; rdata_drv = tbl[i].rdat;
        end

        // reset in BUSY_DM after one wait cycle, late ack
        do_reset();
        @(negedge clk);
        dm_rd = 1'b1; dm_addr = 32'h80;
        @(negedge clk);
        chk("rst_busy_req", 135'(o_mem_req), 135'(1'b1));
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rst_abort%0d", k), outs(), '0);
            rst = 1'b1;
            dm_rd = 1'b0;
            ack_drv = (k == 1);
            rdata_drv = 32'hBAD0BAD0;
        end

        // zero-wait memory, DM read held back-to-back
        do_reset();
        zw_mode = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            ed = (k < 2) ? 32'h0 : 32'h1000 + 32'((k - 2) / 3 * 3 + 1);
            chk($sformatf("zw%0d", k),
                135'({o_mem_req, o_dm_ready, o_dm_rdata,
                      o_mem_addr, o_mem_we}),
                135'({k % 3 == 1, k % 3 == 2, ed,
                      (k == 0) ? 32'h0 : 32'h40, 1'b0}));
            dm_rd = 1'b1; dm_addr = 32'h40;
            rdata_drv = 32'h1000 + 32'(k);
        end

        // continuous tie: RR alternates, fixed priority starves IC
        do_reset();
        zw_mode = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            g = (k - 1) / 3;
            ea = (RR && (g % 2 == 1)) ? 32'h300 : 32'h3000;
            if (k == 0) ea = 32'h0;
            chk($sformatf("tie%0d", k),
                135'({o_mem_req, o_mem_addr, o_ic_ready, o_dm_ready}),
                135'({k % 3 == 1, ea,
                      k % 3 == 2 && ea == 32'h300,
                      k % 3 == 2 && ea == 32'h3000}));
            ic_req = 1'b1; ic_addr = 32'h300;
            dm_rd = 1'b1; dm_addr = 32'h3000;
        end

        // random traffic against the reference model
        zw_mode = 1'b0;
        idle_in();
        m_owner = 0; m_resp = 0; m_last_dm = 0;
        e_req = 0; e_we = 0; e_icr = 0; e_dmr = 0;
        e_addr = 0; e_wd = 0; e_f3 = 0; e_icd = 0; e_dmd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c >= 2)
                chk($sformatf("rand%0d", c), outs(),
                    pk(e_req, e_we, e_addr, e_wd, e_f3,
                       e_icr, e_icd, e_dmr, e_dmd));
            rst = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            ack_drv = ($urandom_range(0, 2) == 0);
            rdata_drv = $urandom;
            if (e_icr || !ic_req) begin
                ic_req = ($urandom_range(0, 2) == 0);
                ic_addr = $urandom;
            end
            if (e_dmr || !(dm_rd || dm_wr)) begin
                int r;
                r = $urandom_range(0, 5);
                dm_rd = (r == 0 || r == 2);
                dm_wr = (r == 1 || r == 2);
                dm_addr = $urandom;
                dm_wd = $urandom;
                dm_f3 = 3'($urandom);
            end
            @(posedge clk);
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
